// File: rtl/text_overlay_fade_if.sv
// Purpose: VGA pixel bus between chain stages: counters, syncs, blanking and 12-bit RGB.
// Latency: none (wires only).
// Backpressure: none; the pixel stream is free-running.
// Signals: hcount/vcount 11-bit pixel counters, hs/vs syncs, hblnk/vblnk blanking, rgb {r,g,b} 4 bits each.
// Modports: master drives the bus, slave receives it.
interface text_overlay_fade_if;
  logic [10:0] hcount;
  logic        hs;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vs;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, hs, hblnk, vcount, vs, vblnk, rgb);
  modport slave  (input  hcount, hs, hblnk, vcount, vs, vblnk, rgb);
endinterface

// File: rtl/text_overlay_fade.sv
// Purpose: overlay that fades the picture in frame steps, then draws scaled, optionally blinking font text.
// Latency: vga_out is vga_in delayed 3 pclk cycles; font ROM address leaves 1 cycle after the pixel arrives.
// Backpressure: none; one pixel in and one pixel out every cycle.
// Ports: pclk/rst (sync, active high); enable/blink levels; vga_in (slave) / vga_out (master) pixel bus;
//        char_xy/char_line font ROM address out, char_pixel ROM row back (bit7 = leftmost); shown = HOLD.
module text_overlay_fade #(
  parameter int          POS_X        = 340,
  parameter int          POS_Y        = 330,
  parameter int          COLS         = 12,
  parameter int          ROWS         = 1,
  parameter int          SCALE_LOG2   = 2,
  parameter logic [11:0] TEXT_COLOR   = 12'hff3,
  parameter int          MAX_DIM      = 2,
  parameter int          STEP_FRAMES  = 8,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       blink,
  input  logic [7:0]                 char_pixel,
  text_overlay_fade_if.slave         vga_in,
  output logic [7:0]                 char_xy,
  output logic [3:0]                 char_line,
  text_overlay_fade_if.master        vga_out,
  output logic                       shown
);

  localparam int          SW         = $clog2(STEP_FRAMES + 1);
  localparam int          BW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [1:0]  LVL_MAX    = 2'(MAX_DIM);
  localparam logic [11:0] BOX_W      = 12'(COLS << (3 + SCALE_LOG2));
  localparam logic [11:0] BOX_H      = 12'(ROWS << (4 + SCALE_LOG2));

  typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} state_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hs;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vs;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  state_t        state_q, state_d;
  logic [1:0]    level_q, level_d;
  logic [SW-1:0] step_q, step_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
  logic          vblnk_prev_q, vblnk_prev_d;
  logic          tick;

  vga_t          bus_in, bus1_q, bus1_d, bus2_q, bus2_d, out_q, out_d;
  logic [7:0]    char_xy_q, char_xy_d;
  logic [3:0]    char_line_q, char_line_d;
  logic          in_box1_q, in_box1_d, in_box2_q, in_box2_d;
  logic [2:0]    bit1_q, bit1_d, bit2_q, bit2_d;
  logic [1:0]    lvl1_q, lvl1_d, lvl2_q, lvl2_d;
  logic          ten1_q, ten1_d, ten2_q, ten2_d;

  logic [11:0]   rel_x, rel_y;
  logic [6:0]    sx;
  logic [7:0]    sy;

  // Frame tick and fade FSM. Leaving a state always restarts the step count; level moves only on ticks.
  always_comb begin
    vblnk_prev_d = vga_in.vblnk;
    tick         = vga_in.vblnk & ~vblnk_prev_q;
    state_d      = state_q;
    level_d      = level_q;
    step_d       = step_q;
    case (state_q)
      IDLE: begin
        level_d = 2'd0;
        if (enable) begin
          state_d = FADE_IN;
          step_d  = '0;
        end
      end
      FADE_IN: begin
        if (!enable) begin
          state_d = FADE_OUT;
          step_d  = '0;
        end else if (level_q == LVL_MAX) begin
          state_d = HOLD;
          step_d  = '0;
        end else if (tick) begin
          if (step_q == STEP_LAST) begin
            level_d = level_q + 2'd1;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      HOLD: begin
        level_d = LVL_MAX;
        if (!enable) begin
          state_d = FADE_OUT;
          step_d  = '0;
        end
      end
      FADE_OUT: begin
        if (enable) begin
          state_d = FADE_IN;
          step_d  = '0;
        end else if (level_q == 2'd0) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (tick) begin
          if (step_q == STEP_LAST) begin
            level_d = level_q - 2'd1;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 2'd0;
        step_d  = '0;
      end
    endcase

    // Blink only runs while held with blink requested; otherwise the text is forced visible.
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if (state_q == HOLD && blink) begin
      blink_cnt_d = blink_cnt_q;
      blink_off_d = blink_off_q;
      if (tick) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_off_d = ~blink_off_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
    end
  end

  // Pixel pipeline: address the font ROM, wait for its registered row, then pick text / dimmed / black.
  always_comb begin
    bus_in = {vga_in.hcount, vga_in.hs, vga_in.hblnk, vga_in.vcount,
              vga_in.vs, vga_in.vblnk, vga_in.rgb};
    // Pixels left of / above the box wrap to large values and fail the box compare.
    rel_x  = {1'b0, vga_in.hcount} - 12'(POS_X);
    rel_y  = {1'b0, vga_in.vcount} - 12'(POS_Y);
    sx     = 7'(rel_x >> SCALE_LOG2);
    sy     = 8'(rel_y >> SCALE_LOG2);

    bus1_d      = bus_in;
    char_xy_d   = {sy[7:4], sx[6:3]};
    char_line_d = sy[3:0];
    bit1_d      = sx[2:0];
    in_box1_d   = (rel_x < BOX_W) && (rel_y < BOX_H);
    lvl1_d      = level_q;
    ten1_d      = (state_q == HOLD) && !blink_off_q;

    bus2_d    = bus1_q;
    in_box2_d = in_box1_q;
    bit2_d    = bit1_q;
    lvl2_d    = lvl1_q;
    ten2_d    = ten1_q;

    out_d = bus2_q;
    if (bus2_q.hblnk || bus2_q.vblnk) begin
      out_d.rgb = 12'h000;
    end else if (ten2_q && in_box2_q && char_pixel[3'd7 - bit2_q]) begin
      out_d.rgb = TEXT_COLOR;
    end else begin
      out_d.rgb = {bus2_q.rgb[11:8] >> lvl2_q, bus2_q.rgb[7:4] >> lvl2_q, bus2_q.rgb[3:0] >> lvl2_q};
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      level_q      <= 2'd0;
      step_q       <= '0;
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
      vblnk_prev_q <= 1'b0;
      bus1_q       <= '0;
      bus2_q       <= '0;
      out_q        <= '0;
      char_xy_q    <= 8'd0;
      char_line_q  <= 4'd0;
      in_box1_q    <= 1'b0;
      in_box2_q    <= 1'b0;
      bit1_q       <= 3'd0;
      bit2_q       <= 3'd0;
      lvl1_q       <= 2'd0;
      lvl2_q       <= 2'd0;
      ten1_q       <= 1'b0;
      ten2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      step_q       <= step_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_off_q  <= blink_off_d;
      vblnk_prev_q <= vblnk_prev_d;
      bus1_q       <= bus1_d;
      bus2_q       <= bus2_d;
      out_q        <= out_d;
      char_xy_q    <= char_xy_d;
      char_line_q  <= char_line_d;
      in_box1_q    <= in_box1_d;
      in_box2_q    <= in_box2_d;
      bit1_q       <= bit1_d;
      bit2_q       <= bit2_d;
      lvl1_q       <= lvl1_d;
      lvl2_q       <= lvl2_d;
      ten1_q       <= ten1_d;
      ten2_q       <= ten2_d;
    end
  end

  assign char_xy        = char_xy_q;
  assign char_line      = char_line_q;
  assign shown          = (state_q == HOLD);
  assign vga_out.hcount = out_q.hcount;
  assign vga_out.hs     = out_q.hs;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.vs     = out_q.vs;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_text_overlay_fade.sv
// Purpose: directed bench for text_overlay_fade with a registered font ROM model and an output scoreboard.
// Latency: expects vga_out 3 cycles after each driven pixel, char_xy/char_line 1 cycle after.
// Backpressure: none; a pixel is driven every cycle while a step runs.
module tb_text_overlay_fade;
  localparam int          POS_X = 340;
  localparam int          POS_Y = 330;
  localparam logic [11:0] TEXT  = 12'hff3;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       blink = 1'b0;
  logic [7:0] char_pixel = 8'h00;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic       shown;

  text_overlay_fade_if vin();
  text_overlay_fade_if vout();

  text_overlay_fade #(
    .POS_X(POS_X), .POS_Y(POS_Y), .COLS(12), .ROWS(1), .SCALE_LOG2(2),
    .TEXT_COLOR(TEXT), .MAX_DIM(2), .STEP_FRAMES(2), .BLINK_FRAMES(3)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .blink(blink),
    .char_pixel(char_pixel), .vga_in(vin), .char_xy(char_xy),
    .char_line(char_line), .vga_out(vout), .shown(shown)
  );

  always #5 pclk = ~pclk;

  // Font ROM model: only glyph line 2 carries a pattern, one cycle after the address.
  logic [7:0] rom_pat = 8'hC1;
  always @(posedge pclk) char_pixel <= (char_line == 4'd2) ? rom_pat : 8'h00;

  typedef struct {
    int          e;
    logic [10:0] h;
    logic        hs, hb;
    logic [10:0] v;
    logic        vs, vb;
    logic [11:0] rgb;
  } exp_t;
  exp_t q[$];

  int          edge_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_level = 0;
  logic        exp_ten = 1'b0;
  logic [11:0] cur_rgb = 12'hfa4;

  always @(posedge pclk) edge_cnt++;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one pixel and push its expected output. elig = inside box on glyph line 2; bn = glyph bit.
  task automatic drive(logic [10:0] h, logic [10:0] v, logic hb, logic vb, logic elig, logic [2:0] bn);
    exp_t        e;
    logic [11:0] r;
    @(posedge pclk);
    #1;
    vin.hcount = h;
    vin.hs     = h[0];
    vin.hblnk  = hb;
    vin.vcount = v;
    vin.vs     = vb;
    vin.vblnk  = vb;
    vin.rgb    = cur_rgb;
    if (hb || vb)
      r = 12'h000;
    else if (exp_ten && elig && rom_pat[7 - bn])
      r = TEXT;
    else
      r = {cur_rgb[11:8] >> exp_level, cur_rgb[7:4] >> exp_level, cur_rgb[3:0] >> exp_level};
    e.e = edge_cnt; e.h = h; e.hs = h[0]; e.hb = hb; e.v = v; e.vs = vb; e.vb = vb; e.rgb = r;
    q.push_back(e);
  endtask

  // One compressed frame: probe pixels around the text box, an hblank cycle, then 4 vblank cycles.
  task automatic frame();
    drive(11'd100, 11'd100, 0, 0, 0, 3'd0);  // far outside
    drive(11'd344, 11'd338, 0, 0, 1, 3'd1);  // rel (4,8): char 0, line 2, bit 1
    drive(11'd340, 11'd338, 0, 0, 1, 3'd0);  // left edge, bit 0
    drive(11'd723, 11'd338, 0, 0, 1, 3'd7);  // last column inside, bit 7
    drive(11'd724, 11'd338, 0, 0, 0, 3'd0);  // first column right of box
    drive(11'd339, 11'd338, 0, 0, 0, 3'd0);  // one left of box (wraps)
    drive(11'd344, 11'd393, 0, 0, 0, 3'd1);  // bottom line inside, glyph line 15
    drive(11'd344, 11'd394, 0, 0, 0, 3'd1);  // one below box
    drive(11'd800, 11'd338, 1, 0, 0, 3'd0);
    for (int i = 0; i < 4; i++) drive(11'd790, 11'd500, 0, 1, 0, 3'd0);
  endtask

  task automatic probe(logic [10:0] h, logic [10:0] v, logic elig, logic [2:0] bn,
                       logic [7:0] xy, logic [3:0] ln, string tag);
    drive(h, v, 0, 0, elig, bn);
    drive(11'd800, v, 1, 0, 0, 3'd0);
    check({tag, "_xy"}, char_xy, xy);
    check({tag, "_line"}, char_line, ln);
  endtask

  always @(negedge pclk) begin
    exp_t e;
    if (q.size() > 0 && q[0].e + 3 == edge_cnt) begin
      e = q.pop_front();
      check("rgb", vout.rgb, e.rgb);
      check("hcount", vout.hcount, e.h);
      check("vcount", vout.vcount, e.v);
      check("sync", {vout.hs, vout.hblnk, vout.vs, vout.vblnk}, {e.hs, e.hb, e.vs, e.vb});
    end
  end

  task automatic check_zero(string tag);
    check({tag, "_rgb"}, vout.rgb, 0);
    check({tag, "_hcount"}, vout.hcount, 0);
    check({tag, "_vcount"}, vout.vcount, 0);
    check({tag, "_sync"}, {vout.hs, vout.hblnk, vout.vs, vout.vblnk}, 0);
    check({tag, "_xy"}, char_xy, 0);
    check({tag, "_line"}, char_line, 0);
    check({tag, "_shown"}, shown, 0);
  endtask

  initial begin
    vin.hcount = 11'd123; vin.hs = 1'b1; vin.hblnk = 1'b0; vin.vcount = 11'd345;
    vin.vs = 1'b1; vin.vblnk = 1'b0; vin.rgb = 12'hfa4;
    repeat (3) @(posedge pclk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Fade-in: two frames per step, level 0,0,1,1 then 2 in HOLD.
    enable = 1'b1;
    frame(); frame();
    check("shown_fade0", shown, 0);
    exp_level = 1;
    frame(); frame();
    check("shown_hold", shown, 1);
    exp_level = 2; exp_ten = 1'b1;
    rom_pat = 8'h40; frame();
    probe(11'd344, 11'd338, 1, 3'd1, 8'h00, 4'd2, "probe_a");
    probe(11'd380, 11'd400, 0, 3'd2, 8'h11, 4'd1, "probe_b");
    rom_pat = 8'h80; frame();
    rom_pat = 8'hC1; frame();

    // Blink: on 3 frames, off, then blink=0 forces visible again.
    blink = 1'b1;
    frame(); frame(); frame();
    exp_ten = 1'b0;
    frame(); frame();
    blink = 1'b0; exp_ten = 1'b1;
    frame();

    // Reset in HOLD with a non-trivial pixel in flight.
    repeat (4) @(posedge pclk);
    #1;
    vin.hcount = 11'd380; vin.hs = 1'b0; vin.hblnk = 1'b0; vin.vcount = 11'd400;
    vin.vs = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'hfa4;
    @(posedge pclk);
    #1;
    check("pre_rst_xy", char_xy, 8'h11);
    check("pre_rst_shown", shown, 1);
    rst = 1'b1;
    @(posedge pclk);
    #1;
    check_zero("rst_hold");
    enable = 1'b0;
    @(posedge pclk);
    #1;
    rst = 1'b0;
    exp_level = 0; exp_ten = 1'b0;
    frame();

    // Reversal: drop enable at level 1, fade back to IDLE.
    enable = 1'b1;
    frame(); frame();
    exp_level = 1; enable = 1'b0;
    frame(); frame();
    check("shown_fadeout", shown, 0);
    exp_level = 0;
    frame();
    // Climb to level 1 again, reverse, then re-assert: resumes from level 1 with a fresh step count.
    enable = 1'b1;
    frame(); frame();
    exp_level = 1; enable = 1'b0;
    frame();
    enable = 1'b1;
    frame(); frame();
    exp_level = 2; exp_ten = 1'b1;
    frame();
    check("shown_rehold", shown, 1);

    repeat (6) @(posedge pclk);
    #1;
    check("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
